mac_seq: RTL and testbench
==========================

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter DW, default 8, operand width in sign-magnitude (MSB sign, DW-1 magnitude bits).
REQ-002 Parameter AW, default 16, accumulator/result width, two's complement, AW >= 2*DW.
REQ-003 Parameter LEN, default 9, number of products per accumulation, 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  begin an accumulation; sampled in IDLE only.
REQ-007 bias  input  DW  sign-magnitude initial accumulator value, sampled with start.
REQ-008 in_valid  input  1  a/b pair valid.
REQ-009 in_ready  output  1  block accepts a/b this cycle.
REQ-010 a, b  input  DW each  sign-magnitude operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  AW  accumulated result, two's complement.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 ovf  output  1  sticky overflow flag for the current accumulation.

Function
REQ-016 FSM states IDLE, ACC, DRAIN, DONE; IDLE -> ACC on start; ACC -> DRAIN on the LEN-th accepted pair; DRAIN -> DONE after one cycle; DONE -> IDLE when out_valid and out_ready both high.
REQ-017 On start in IDLE: acc loads bias converted to two's complement and sign-extended to AW, term counter clears to 0, ovf clears to 0.
REQ-018 start outside IDLE is ignored.
REQ-019 in_ready is high only in ACC; a pair is accepted in a cycle with in_valid and in_ready both high.
REQ-020 Product: magnitude = a[DW-2:0] * b[DW-2:0] (2*DW-2 bits), sign = a[DW-1] XOR b[DW-1]; converted to two's complement and sign-extended to AW; zero magnitude yields 0 regardless of sign.
REQ-021 Product registered in a one-stage pipeline; added into acc the cycle after acceptance (2-cycle input-to-acc latency).
REQ-022 Back-to-back acceptance at one pair per cycle; in_valid low cycles stall the counter and add nothing.
REQ-023 Overflow: a signed add whose true result lies outside the AW-bit range sets ovf, which stays set until the next start or reset.
REQ-024 In DONE: out_valid=1, out=acc, held stable while out_ready is low.
REQ-025 out shows acc in all states; out_valid is 0 outside DONE.
REQ-026 LEN=1: exactly one pair accepted, then DRAIN.

Reset
REQ-027 rst high forces state IDLE, acc=0, counter=0, pipeline register=0, ovf=0, out_valid=0, in_ready=0, busy=0, out=0 immediately, independent of clk.
REQ-028 rst mid-accumulation discards all partial results; the next accumulation requires a new start.

Configuration
REQ-029 Macro MAC_SEQ_SAT_EN: when defined, an overflowing add clamps acc to 2^(AW-1)-1 (positive) or -2^(AW-1) (negative); when undefined, acc wraps modulo 2^AW; ovf behaves identically in both builds.

Verification (DW=8, AW=16, LEN=3 unless stated)
REQ-030 bias=8'h05, pairs (8'h03,8'h04),(8'h82,8'h06),(8'h0A,8'h0A) back-to-back -> out=16'h0069, ovf=0, out_valid exactly 4 cycles after the first accepted pair.
REQ-031 bias=8'h7F, three pairs (8'h7F,8'h7F) -> ovf=1; with MAC_SEQ_SAT_EN out=16'h7FFF; without it out=16'hBD82.
REQ-032 bias=8'h00, pairs (8'h80,8'h05),(8'h00,8'h85),(8'h81,8'h81) with in_valid low for 2 cycles between pairs -> out=16'h0001, counter advances only on accepted pairs.
REQ-033 Result ready, out_ready low for 5 cycles -> out_valid and out held constant; out_ready high -> IDLE next cycle, busy=0; start asserted during DONE ignored.
REQ-034 rst pulsed after the second accepted pair -> all outputs 0 asynchronously; new start with bias=8'h81 and pairs (8'h02,8'h02)x3 -> out=16'h000B.

Source files
------------

// File: rtl/mac_seq.sv
// Sequential sign-magnitude multiply-accumulate with a registered product stage.
// Define MAC_SEQ_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_seq #(
    parameter int DW  = 8,
    parameter int AW  = 16,
    parameter int LEN = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] bias,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out,
    output logic          busy,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    localparam logic [7:0] LAST = 8'(LEN - 1);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cnt;
    logic [AW-1:0] acc;
    logic [AW-1:0] prod_q;
    logic          prod_vld;

    logic          take;
    logic          last;
    logic [2*DW-3:0] pmag;
    logic [AW-1:0] pext;
    logic [AW-1:0] prod;
    logic [AW-1:0] bias_mag;
    logic [AW-1:0] bias_ext;
    logic [AW-1:0] sum;
    logic          sum_ovf;
    logic [AW-1:0] acc_nxt;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out       = acc;

    assign take = in_valid && in_ready;
    assign last = (cnt == LAST);

    assign pmag = {{(DW-1){1'b0}}, a[DW-2:0]} * {{(DW-1){1'b0}}, b[DW-2:0]};
    assign pext = {{(AW-2*DW+2){1'b0}}, pmag};
    // Negating a zero magnitude gives zero, so -0 operands need no special case
    assign prod = (a[DW-1] ^ b[DW-1]) ? -pext : pext;

    assign bias_mag = {{(AW-DW+1){1'b0}}, bias[DW-2:0]};
    assign bias_ext = bias[DW-1] ? -bias_mag : bias_mag;

    assign sum     = acc + prod_q;
    assign sum_ovf = (acc[AW-1] == prod_q[AW-1]) && (sum[AW-1] != acc[AW-1]);

`ifdef MAC_SEQ_SAT_EN
    always_comb begin
        acc_nxt = sum;
        if (sum_ovf)
            acc_nxt = acc[AW-1] ? {1'b1, {(AW-1){1'b0}}}
                                : {1'b0, {(AW-1){1'b1}}};
    end
`else
    assign acc_nxt = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (take && last) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            prod_q   <= '0;
            prod_vld <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            prod_vld <= take;
            if (take) begin
                prod_q <= prod;
                cnt    <= cnt + 8'd1;
            end
            // No product is ever in flight while IDLE, so start never races an add
            if (state == IDLE && start) begin
                acc <= bias_ext;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (prod_vld) begin
                acc <= acc_nxt;
                if (sum_ovf) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq (DW=8, AW=16, LEN=3) with a queued scoreboard.
module tb_mac_seq;

    typedef struct packed {
        logic [15:0] res;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    mac_seq #(.DW(8), .AW(16), .LEN(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare at every result handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(out), 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_out", 32'(out), 32'(e.res));
                chk("result_ovf", 32'(ovf), 32'(e.ov));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] bv);
        start = 1'b1;
        bias  = bv;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic run(input logic [7:0] bv, input logic [7:0] av[3],
                       input logic [7:0] bb[3], input int gap,
                       input logic [15:0] er, input logic eo,
                       input bit check_lat);
        int n;
        int lat;
        sb.push_back('{res: er, ov: eo});
        do_start(bv);
        chk("in_ready_acc", 32'(in_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = av[i];
            b = bb[i];
            step();
            lat++;
            in_valid = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    lat++;
                    chk("stall_in_ready", 32'(in_ready), 32'd1);
                end
            end
        end
        wait_valid(n);
        if (check_lat) chk("latency", 32'(lat + n), 32'd4);
        if (out_ready) begin
            step();
            chk("idle_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] av[3];
        logic [7:0] bb[3];
        int n;

        #2;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        step();
        rst = 1'b0;
        step();

        av = '{8'h03, 8'h82, 8'h0A};
        bb = '{8'h04, 8'h06, 8'h0A};
        run(8'h05, av, bb, 0, 16'h0069, 1'b0, 1'b1);

        av = '{8'h7F, 8'h7F, 8'h7F};
        bb = '{8'h7F, 8'h7F, 8'h7F};
`ifdef MAC_SEQ_SAT_EN
        run(8'h7F, av, bb, 0, 16'h7FFF, 1'b1, 1'b0);
`else
        run(8'h7F, av, bb, 0, 16'hBD82, 1'b1, 1'b0);
`endif

        av = '{8'h80, 8'h00, 8'h81};
        bb = '{8'h05, 8'h85, 8'h81};
        run(8'h00, av, bb, 2, 16'h0001, 1'b0, 1'b0);

        // Hold result under backpressure, start during DONE ignored
        out_ready = 1'b0;
        av = '{8'h03, 8'h82, 8'h0A};
        bb = '{8'h04, 8'h06, 8'h0A};
        run(8'h05, av, bb, 0, 16'h0069, 1'b0, 1'b0);
        start = 1'b1;
        bias  = 8'h11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_out", 32'(out), 32'h0069);
        end
        out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_valid", 32'(out_valid), 32'd0);
        step();
        chk("start_in_done_ignored", 32'(busy), 32'd0);

        // Asynchronous reset mid-accumulation
        do_start(8'h05);
        in_valid = 1'b1;
        a = 8'h03;
        b = 8'h04;
        step();
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("arst_stays_idle", 32'(busy), 32'd0);

        av = '{8'h02, 8'h02, 8'h02};
        bb = '{8'h02, 8'h02, 8'h02};
        run(8'h81, av, bb, 0, 16'h000B, 1'b0, 1'b0);

        step();
        step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
